// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the FIFO packet writer: state encoding and framing constants.
package fifo_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DONE
   } pkt_state_e;

   localparam logic [7:0]  HDR_MAGIC = 8'hA5;
   localparam int unsigned MAX_LEN   = 8;

endpackage

// File: rtl/fifo_pkt_writer.sv
// Frames a payload of 1..MAX_LEN words as header, payload, XOR checksum and
// pushes it into a FIFO write port, stalling on fifo_full and source gaps.
module fifo_pkt_writer
   import fifo_pkt_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4
) (
   input  logic              wr_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   input  logic              fifo_full,
   output logic              fifo_en,
   output logic              fifo_wr,
   output logic [DATA_W-1:0] fifo_data,
   output logic              busy,
   output logic              done
);

   pkt_state_e        state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [DATA_W-1:0] csum_q;
   logic              busy_q;
   logic              done_q;

   logic              len_ok;
   logic              pay_hs;
   logic [DATA_W-1:0] hdr_word;

   assign len_ok = (len != '0) && (32'(len) <= MAX_LEN);
   assign pay_hs = (state_q == ST_PAYLOAD) && src_valid && !fifo_full;

   always_comb begin
      hdr_word                  = '0;
      hdr_word[DATA_W-1 -: 8]   = HDR_MAGIC;
      hdr_word[LEN_W-1:0]       = len_q;
   end

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && len_ok) begin
                  len_q   <= len;
                  cnt_q   <= len;
                  csum_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (!fifo_full)
                  state_q <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (pay_hs) begin
                  csum_q <= csum_q ^ src_data;
                  // saturate rather than wrap; last word is detected at one
                  if (cnt_q != '0)
                     cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == LEN_W'(1))
                     state_q <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (!fifo_full) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      fifo_wr   = 1'b0;
      fifo_data = '0;
      case (state_q)
         ST_HEADER: begin
            fifo_wr   = !fifo_full;
            fifo_data = hdr_word;
         end
         ST_PAYLOAD: begin
            fifo_wr   = src_valid && !fifo_full;
            fifo_data = src_data;
         end
         ST_CSUM: begin
            fifo_wr   = !fifo_full;
            fifo_data = csum_q;
         end
         default: begin
            fifo_wr   = 1'b0;
            fifo_data = '0;
         end
      endcase
   end

   assign src_ready = (state_q == ST_PAYLOAD) && !fifo_full;
   assign fifo_en   = busy_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed bench for fifo_pkt_writer: logs every FIFO write and compares
// against hand-computed packet contents and cycle positions.
module tb_fifo_pkt_writer;

   logic        wr_clk;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic        fifo_full;
   logic        fifo_en;
   logic        fifo_wr;
   logic [31:0] fifo_data;
   logic        busy;
   logic        done;

   fifo_pkt_writer #(.DATA_W(32), .LEN_W(4)) dut (
      .wr_clk    (wr_clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .fifo_full (fifo_full),
      .fifo_en   (fifo_en),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .busy      (busy),
      .done      (done)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          hs    = 0;
   int          pbase = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   logic        gap = 1'b0;
   logic [31:0] pay [8];
   logic [31:0] wq [$];
   int          wc [$];
   logic [31:0] ex [$];

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   assign src_data = pay[(hs - pbase) & 7];

   always @(posedge wr_clk) begin
      cyc <= cyc + 1;
      if (src_valid && src_ready)
         hs <= hs + 1;
   end

   always @(negedge wr_clk) begin
      if (fifo_en && fifo_wr && !fifo_full) begin
         wq.push_back(fifo_data);
         wc.push_back(cyc);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
      if (gap)
         src_valid = ~src_valid;
   endtask

   task automatic wait_done(input int lim);
      int n;
      n = 0;
      while (!done && n < lim) begin
         tick();
         n++;
      end
      check("done_within_bound", done, 1'b1);
   endtask

   task automatic chk_log(input string tag, input int wb);
      check({tag, "_nwrites"}, wq.size() - wb, ex.size());
      for (int i = 0; i < ex.size(); i++)
         if (wb + i < wq.size())
            check($sformatf("%s_w%0d", tag, i), wq[wb + i], ex[i]);
   endtask

   task automatic chk_zero_outs(input string tag);
      check({tag, "_fifo_en"},   fifo_en,   1'b0);
      check({tag, "_fifo_wr"},   fifo_wr,   1'b0);
      check({tag, "_fifo_data"}, fifo_data, 32'h0);
      check({tag, "_src_ready"}, src_ready, 1'b0);
      check({tag, "_busy"},      busy,      1'b0);
      check({tag, "_done"},      done,      1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, wb, db, dc;
      rst       = 1'b1;
      start     = 1'b1;
      len       = 4'd3;
      src_valid = 1'b1;
      fifo_full = 1'b0;
      for (int i = 0; i < 8; i++) pay[i] = '0;
      #1;
      chk_zero_outs("reset");
      tick();
      tick();
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("idle_after_reset", busy, 1'b0);

      // basic packet, len=3
      pbase = hs;
      pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h44;
      wb = wq.size(); db = done_cnt;
      start = 1'b1; len = 4'd3; c0 = cyc;
      tick();
      start = 1'b0; len = 4'd0;
      check("basic_hdr_data", fifo_data, 32'hA500_0003);
      check("basic_busy", busy, 1'b1);
      wait_done(20);
      tick(); tick();
      ex = '{32'hA500_0003, 32'h11, 32'h22, 32'h44, 32'h77};
      chk_log("basic", wb);
      if (wq.size() >= wb + 5) begin
         check("basic_hdr_cycle", wc[wb], c0 + 1);
         check("basic_csum_cycle", wc[wb + 4], c0 + 5);
      end
      check("basic_done_cycle", done_cyc, c0 + 6);
      check("basic_done_pulses", done_cnt - db, 1);
      check("basic_idle", busy, 1'b0);

      // fifo_full stall in PAYLOAD, len=2
      pbase = hs;
      pay[0] = 32'hDEAD_BEEF; pay[1] = 32'h0123_4567;
      wb = wq.size();
      start = 1'b1; len = 4'd2; c0 = cyc;
      tick();
      start = 1'b0;
      tick();
      fifo_full = 1'b1;
      #1;
      check("stall_src_ready", src_ready, 1'b0);
      check("stall_fifo_wr", fifo_wr, 1'b0);
      check("stall_fifo_en", fifo_en, 1'b1);
      repeat (4) tick();
      check("stall_no_writes", wq.size() - wb, 1);
      fifo_full = 1'b0;
      wait_done(20);
      tick();
      ex = '{32'hA500_0002, 32'hDEAD_BEEF, 32'h0123_4567, 32'hDF8E_FB88};
      chk_log("stall", wb);
      check("stall_done_cycle", done_cyc, c0 + 9);

      // source gaps, len=8
      pbase = hs;
      for (int i = 0; i < 8; i++) pay[i] = 32'h1 << (4 * i);
      wb = wq.size();
      start = 1'b1; len = 4'd8; gap = 1'b1;
      tick();
      start = 1'b0;
      wait_done(60);
      gap = 1'b0; src_valid = 1'b1;
      tick();
      ex = '{32'hA500_0008, 32'h0000_0001, 32'h0000_0010, 32'h0000_0100, 32'h0000_1000,
             32'h0001_0000, 32'h0010_0000, 32'h0100_0000, 32'h1000_0000, 32'h1111_1111};
      chk_log("gaps", wb);
      if (wq.size() >= wb + 10)
         check("gaps_done_after_last", done_cyc, wc[wb + 9] + 1);

      // illegal lengths, then start held high through a whole packet
      wb = wq.size(); db = done_cnt;
      start = 1'b1; len = 4'd0;
      tick();
      check("len0_ignored", busy, 1'b0);
      len = 4'd9;
      tick();
      check("len9_ignored", busy, 1'b0);
      start = 1'b0;
      tick();
      check("illegal_no_writes", wq.size() - wb, 0);
      pbase = hs;
      pay[0] = 32'h1234_5678;
      start = 1'b1; len = 4'd1;
      repeat (4) tick();
      check("busy_start_done_cycle", done, 1'b1);
      tick();
      start = 1'b0;
      check("start_in_done_ignored", busy, 1'b0);
      tick();
      check("still_idle", busy, 1'b0);
      ex = '{32'hA500_0001, 32'h1234_5678, 32'h1234_5678};
      chk_log("busystart", wb);
      check("busystart_done_pulses", done_cnt - db, 1);

      // reset after two payload words
      pbase = hs;
      pay[0] = 32'h1; pay[1] = 32'h2; pay[2] = 32'h3; pay[3] = 32'h4;
      wb = wq.size();
      start = 1'b1; len = 4'd4;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk_zero_outs("midrst");
      tick(); tick();
      rst = 1'b0;
      tick();
      check("midrst_idle", busy, 1'b0);
      check("midrst_writes", wq.size() - wb, 3);
      pbase = hs;
      pay[0] = 32'hCAFE_F00D;
      wb = wq.size();
      start = 1'b1; len = 4'd1;
      tick();
      start = 1'b0;
      wait_done(20);
      tick();
      ex = '{32'hA500_0001, 32'hCAFE_F00D, 32'hCAFE_F00D};
      chk_log("postrst", wb);

      // back-to-back: second start in the cycle right after done
      pbase = hs;
      pay[0] = 32'h5; pay[1] = 32'h6; pay[2] = 32'h7;
      wb = wq.size(); db = done_cnt;
      start = 1'b1; len = 4'd2;
      tick();
      start = 1'b0;
      wait_done(20);
      dc = cyc;
      tick();
      start = 1'b1; len = 4'd1;
      tick();
      start = 1'b0;
      wait_done(20);
      tick();
      ex = '{32'hA500_0002, 32'h5, 32'h6, 32'h3, 32'hA500_0001, 32'h7, 32'h7};
      chk_log("b2b", wb);
      if (wq.size() >= wb + 5)
         check("b2b_hdr2_cycle", wc[wb + 4], dc + 2);
      check("b2b_done_pulses", done_cnt - db, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
